pipe_stall_ctrl: RTL
====================

Name: pipe_stall_ctrl

Overview:
Central pipeline control for the 5-stage core. It arbitrates stall requests from ID (the branch/operand hazard stall), EX (multi-cycle divide) and MEM (data-bus wait) into a per-stage stall vector. It sequences exception flushes: it latches the handler PC and drives a timed flush pulse. It also keeps a stall-cycle performance counter and a stuck-stall watchdog. It sits beside the pipeline registers (pc_reg, if_id, id_ex, ex_mem, mem_wb), which consume its outputs.

Parameters:
FLUSH_CYCLES, 1, number of consecutive cycles flush_o stays high per exception (legal range 1..7).
WDT_LIMIT, 1023, consecutive stalled cycles before wdt_timeout_o sets (legal range 1..65535).

Ports:
clk_i  input  1  core clock; all state updates on the rising edge.
rst_i  input  1  synchronous reset, active-high.
stallreq_id_i  input  1  ID-stage stall request (operand/branch hazard against EX).
stallreq_ex_i  input  1  EX-stage stall request (divider busy).
stallreq_mem_i  input  1  MEM-stage stall request (data bus not ready).
excp_valid_i  input  1  exception committed in MEM this cycle.
excp_pc_i  input  32  handler address, valid with excp_valid_i.
perf_clr_i  input  1  synchronous clear of the perf counter and watchdog.
stall_o  output  6  stall vector: bit0 pc, bit1 if, bit2 id, bit3 ex, bit4 mem, bit5 wb.
flush_o  output  1  flush all pipeline registers and redirect PC.
new_pc_o  output  32  redirect target, valid while flush_o=1.
stall_cycles_o  output  32  saturating count of cycles with stall_o != 0.
wdt_timeout_o  output  1  sticky: a stall persisted WDT_LIMIT consecutive cycles.

Behaviour:
- Reset (rst_i=1 at an edge): state to IDLE; flush_o=0; new_pc_o=0; stall_cycles_o=0; wdt_timeout_o=0; internal counters 0.
- While rst_i=1, stall_o=0 combinationally.
- Reset mid-flush or mid-stall aborts the operation immediately; no residual pulse follows.
- stall_o is combinational, fixed priority:
  - rst_i, state FLUSH, or excp_valid_i gives 6'b000000. An exception overrides all stalls.
  - else stallreq_mem_i gives 6'b011111.
  - else stallreq_ex_i gives 6'b001111.
  - else stallreq_id_i gives 6'b000111.
  - else 6'b000000.
- Stall bits are always contiguous from bit0; the wb bit is never stalled.
- FSM states:
  - IDLE: excp_valid_i=1 at an edge moves to FLUSH. The same edge registers flush_o=1 and new_pc_o=excp_pc_i, and loads the flush counter with FLUSH_CYCLES-1.
  - FLUSH: flush_o=1 and new_pc_o held. excp_valid_i is ignored. The counter decrements each edge. An edge with counter=0 returns to IDLE and clears flush_o=0. new_pc_o keeps its last value.
- Flush latency: flush_o rises exactly 1 cycle after excp_valid_i and stays high FLUSH_CYCLES cycles.
- Back-to-back exceptions: an excp_valid_i on the same edge that leaves FLUSH is dropped. The first one accepted is on the next edge in IDLE.
- Perf counter:
  - Each edge with stall_o != 0 increments stall_cycles_o.
  - It saturates at 32'hFFFF_FFFF and does not wrap.
  - perf_clr_i=1 sets it to 0 and takes priority over an increment on the same edge.
- Watchdog:
  - A 16-bit run counter increments each edge with stall_o != 0 and resets to 0 on any edge with stall_o == 0.
  - When the counter reaches WDT_LIMIT, wdt_timeout_o sets to 1 on that edge, i.e. after WDT_LIMIT consecutive stalled edges.
  - The counter saturates at WDT_LIMIT.
  - wdt_timeout_o stays set until rst_i or perf_clr_i. perf_clr_i also zeroes the run counter.
- Simultaneous requests: the highest-priority source wins. Lower sources are implicitly satisfied because their stages are frozen too.

Test Plan:
- Reset: hold rst_i 2 cycles with all requests high -> stall_o=0, flush_o=0, stall_cycles_o=0, wdt_timeout_o=0.
- Priority: stallreq_id_i=1 gives stall_o=6'b000111. Adding stallreq_ex_i=1 gives 6'b001111. Adding stallreq_mem_i=1 gives 6'b011111. Dropping all gives 0.
- Exception: pulse excp_valid_i 1 cycle with excp_pc_i=32'hBFC00380 and stallreq_mem_i=1.
  - Same cycle: stall_o=0.
  - Next cycle: flush_o=1, new_pc_o=32'hBFC00380 for FLUSH_CYCLES cycles.
  - A second excp_valid_i during FLUSH is ignored.
- Exception timing with FLUSH_CYCLES=3: flush_o is high for exactly 3 cycles, then 0. Reset asserted during the 2nd flush cycle drops flush_o to 0 on that edge.
- Perf counter: hold stallreq_ex_i for 10 cycles -> stall_cycles_o=10. Assert perf_clr_i together with a stall -> 0. Preload near 32'hFFFF_FFFF and keep stalling -> holds at 32'hFFFF_FFFF.
- Watchdog with WDT_LIMIT=8:
  - 7 stalled cycles, 1 free cycle, then 7 stalled -> wdt_timeout_o stays 0.
  - 8 consecutive stalled cycles -> wdt_timeout_o=1 and it stays set after the stalls end.
  - perf_clr_i clears it.

Source files
------------

// File: rtl/pipe_stall_ctrl_if.sv
// Pipeline <-> stall controller bundle: stall requests and exception commit in,
// per-stage stall vector, flush redirect and perf/watchdog status out.
interface pipe_stall_ctrl_if;
    logic        stallreq_id_i;
    logic        stallreq_ex_i;
    logic        stallreq_mem_i;
    logic        excp_valid_i;
    logic [31:0] excp_pc_i;
    logic        perf_clr_i;
    logic [5:0]  stall_o;
    logic        flush_o;
    logic [31:0] new_pc_o;
    logic [31:0] stall_cycles_o;
    logic        wdt_timeout_o;

    modport master (
        output stallreq_id_i, stallreq_ex_i, stallreq_mem_i,
        output excp_valid_i, excp_pc_i, perf_clr_i,
        input  stall_o, flush_o, new_pc_o, stall_cycles_o, wdt_timeout_o
    );

    modport slave (
        input  stallreq_id_i, stallreq_ex_i, stallreq_mem_i,
        input  excp_valid_i, excp_pc_i, perf_clr_i,
        output stall_o, flush_o, new_pc_o, stall_cycles_o, wdt_timeout_o
    );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// Central 5-stage pipeline control: prioritised stall vector, timed exception
// flush sequencer, saturating stall-cycle counter and stuck-stall watchdog.
module pipe_stall_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned WDT_LIMIT    = 1023
) (
    input  logic              clk_i,
    input  logic              rst_i,
    pipe_stall_ctrl_if.slave  bus
);
    localparam logic [2:0]  FCNT_INIT = 3'(FLUSH_CYCLES - 1);
    localparam logic [15:0] WDT_LIM   = 16'(WDT_LIMIT);

    typedef enum logic {IDLE, FLUSH} state_t;

    state_t      state_q, state_d;
    logic [2:0]  fcnt_q, fcnt_d;
    logic        flush_q, flush_d;
    logic [31:0] new_pc_q, new_pc_d;
    logic [31:0] perf_q, perf_d;
    logic [15:0] run_q, run_d;
    logic        wdt_q, wdt_d;
    logic [5:0]  stall;
    logic        stall_any;

    // Exceptions and an active flush override every stall source.
    always_comb begin
        stall = 6'b000000;
        if (rst_i || state_q == FLUSH || bus.excp_valid_i) stall = 6'b000000;
        else if (bus.stallreq_mem_i)                       stall = 6'b011111;
        else if (bus.stallreq_ex_i)                        stall = 6'b001111;
        else if (bus.stallreq_id_i)                        stall = 6'b000111;
    end
    assign stall_any = |stall;

    always_comb begin
        state_d  = state_q;
        fcnt_d   = fcnt_q;
        flush_d  = flush_q;
        new_pc_d = new_pc_q;
        case (state_q)
            IDLE: if (bus.excp_valid_i) begin
                state_d  = FLUSH;
                flush_d  = 1'b1;
                new_pc_d = bus.excp_pc_i;
                fcnt_d   = FCNT_INIT;
            end
            FLUSH: if (fcnt_q == 3'd0) begin
                state_d = IDLE;
                flush_d = 1'b0;
            end else begin
                fcnt_d = fcnt_q - 3'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        perf_d = perf_q;
        run_d  = run_q;
        wdt_d  = wdt_q;
        if (bus.perf_clr_i) begin
            perf_d = '0;
            run_d  = '0;
            wdt_d  = 1'b0;
        end else if (stall_any) begin
            if (perf_q != 32'hFFFF_FFFF) perf_d = perf_q + 32'd1;
            if (run_q != WDT_LIM)        run_d  = run_q + 16'd1;
            if (run_d == WDT_LIM)        wdt_d  = 1'b1;
        end else begin
            run_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            fcnt_q   <= '0;
            flush_q  <= 1'b0;
            new_pc_q <= '0;
            perf_q   <= '0;
            run_q    <= '0;
            wdt_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            fcnt_q   <= fcnt_d;
            flush_q  <= flush_d;
            new_pc_q <= new_pc_d;
            perf_q   <= perf_d;
            run_q    <= run_d;
            wdt_q    <= wdt_d;
        end
    end

    assign bus.stall_o        = stall;
    assign bus.flush_o        = flush_q;
    assign bus.new_pc_o       = new_pc_q;
    assign bus.stall_cycles_o = perf_q;
    assign bus.wdt_timeout_o  = wdt_q;
endmodule
